insn_encoder: RTL

Packs decoded instruction fields (opcode, registers, immediate, target) into 32-bit ISA instruction words and streams them out through a 2-entry valid/ready buffer with a running instruction address. It sits on the instruction-memory write path (program loader / self-test generator) and is the inverse of the opcode-to-control decode in the processor core. The encoder applies the same opcode map as the core's decoder: any opcode that the decoder treats as illegal is rejected here before it reaches memory.

---
 rtl/insn_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/insn_encoder.sv
// Instruction word encoder: packs decoded fields into 32-bit ISA words and
// queues them with a running address in a 2-entry valid/ready buffer.
module insn_encoder #(
    parameter int unsigned       ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        drop_count
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_JI,
        FMT_JII,
        FMT_BAD
    } fmt_t;

    fmt_t              fmt;
    logic [31:0]       enc_word;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;

    logic [31:0]       mem_insn [2];
    logic [ADDR_W-1:0] mem_addr [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_q;

    // Opcode map must match the core's decoder exactly.
    always_comb begin
        fmt = FMT_BAD;
        case (in_op)
            5'b00000:                                        fmt = FMT_R;
            5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: fmt = FMT_I;
            5'b00001, 5'b00011, 5'b10110, 5'b10101:           fmt = FMT_JI;
            5'b00100:                                        fmt = FMT_JII;
            default:                                         fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        enc_word = '0;
        case (fmt)
            FMT_R:   enc_word = {in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            FMT_I:   enc_word = {in_op, in_rd, in_rs, in_imm};
            FMT_JI:  enc_word = {in_op, in_target};
            FMT_JII: enc_word = {in_op, in_rd, 22'd0};
            default: enc_word = '0;
        endcase
    end

    // Ready comes only from registered occupancy; a full buffer refuses input
    // even when the head is being popped in the same cycle.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_insn  = mem_insn[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];

    assign accept = in_valid & in_ready;
    assign push   = accept & (fmt != FMT_BAD);
    assign drop   = accept & (fmt == FMT_BAD);
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_insn[i] <= '0;
                mem_addr[i] <= BASE_ADDR;
            end
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            addr_q      <= BASE_ADDR;
            err_illegal <= 1'b0;
            drop_count  <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_insn[i] <= '0;
                mem_addr[i] <= BASE_ADDR;
            end
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            addr_q      <= BASE_ADDR;
            err_illegal <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push) begin
                mem_insn[wr_ptr] <= enc_word;
                mem_addr[wr_ptr] <= addr_q;
                wr_ptr           <= ~wr_ptr;
                addr_q           <= addr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (drop) begin
                err_illegal <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule
